// File: rtl/snn_pkg.sv
// Shared sizes, types and sweep-state encoding for the neuron membrane datapath.
package snn_pkg;

  localparam int NEURON_NO = 2**8;
  localparam int AMPL_WID  = 20;
  localparam int REF_WID   = 4;
  localparam int NA        = (NEURON_NO > 1) ? $clog2(NEURON_NO) : 1;

  typedef logic        [NA-1:0]       addr_t;
  typedef logic        [AMPL_WID-1:0] ampl_t;
  typedef logic signed [AMPL_WID:0]   pot_t;
  typedef logic        [NA:0]         cnt_t;
  typedef logic        [REF_WID-1:0]  ref_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;

endpackage

// File: rtl/membrane_scan_if.sv
// Amplitude-store read port, spike/potential result bus and sweep status of membrane_scan.
// The refractory period input exists only when REFRACTORY_EN is defined.
interface membrane_scan_if;
  import snn_pkg::*;

  logic  tick;
  pot_t  v_th;
  ampl_t ampl_a_in;
  ampl_t ampl_b_in;
`ifdef REFRACTORY_EN
  ref_t  ref_period;
`endif
  logic  rd_en;
  addr_t rd_addr;
  logic  sp_out;
  addr_t sp_addr;
  pot_t  v_out;
  logic  v_valid;
  logic  busy;
  logic  done;
  cnt_t  spike_cnt;
  logic  overrun;

  modport master (
    input  tick, v_th, ampl_a_in, ampl_b_in,
`ifdef REFRACTORY_EN
    input  ref_period,
`endif
    output rd_en, rd_addr, sp_out, sp_addr, v_out, v_valid,
    output busy, done, spike_cnt, overrun
  );

  modport slave (
    output tick, v_th, ampl_a_in, ampl_b_in,
`ifdef REFRACTORY_EN
    output ref_period,
`endif
    input  rd_en, rd_addr, sp_out, sp_addr, v_out, v_valid,
    input  busy, done, spike_cnt, overrun
  );

endinterface

// File: rtl/membrane_scan_calc.sv
// Stage 1 of the membrane pipeline: v = A - B, threshold compare, registered result.
// With REFRACTORY_EN a per-neuron countdown suppresses spikes after each firing.
module membrane_calc
  import snn_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  vld_p0,
  input  ampl_t a_p0,
  input  ampl_t b_p0,
  input  addr_t addr_p0,
  input  pot_t  v_th,
`ifdef REFRACTORY_EN
  input  ref_t  ref_period,
`endif
  output logic  vld_p1,
  output logic  spk_p1,
  output pot_t  v_p1,
  output addr_t addr_p1
);

  // Zero-extended operands make the difference exact in AMPL_WID+1 signed bits.
  function automatic pot_t calc_pot(input ampl_t a, input ampl_t b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  pot_t v_c;
  logic spk_c;

  assign v_c = calc_pot(a_p0, b_p0);

`ifdef REFRACTORY_EN
  ref_t ctr [NEURON_NO];
  logic blocked;

  assign blocked = (ctr[addr_p0] != '0);
  assign spk_c   = (v_c >= v_th) && !blocked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NEURON_NO; i++) ctr[i] <= '0;
    end else if (vld_p0) begin
      if (blocked)    ctr[addr_p0] <= ctr[addr_p0] - ref_t'(1);
      else if (spk_c) ctr[addr_p0] <= ref_period;
    end
  end
`else
  assign spk_c = (v_c >= v_th);
`endif

  // ---- stage 0 -> stage 1 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      spk_p1  <= 1'b0;
      v_p1    <= '0;
      addr_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      spk_p1 <= vld_p0 & spk_c;
      if (vld_p0) begin
        v_p1    <= v_c;
        addr_p1 <= addr_p0;
      end
    end
  end

endmodule

// File: rtl/membrane_scan.sv
// Per-timestep neuron sweep: reads every neuron's (A, B), evaluates v = A - B against v_th
// and reports spikes LAT cycles after each read. Optional macro: REFRACTORY_EN.
module membrane_scan
  import snn_pkg::*;
#(
  parameter int LAT = 3
) (
  input logic      clk,
  input logic      reset,
  membrane_scan_if.master bus
);

  localparam addr_t LAST_ADDR = addr_t'(NEURON_NO - 1);
  localparam int    DCW       = $clog2(LAT) + 1;
  localparam logic [DCW-1:0] DRAIN_END = DCW'(LAT - 2);

  function automatic cnt_t sat_inc(input cnt_t c, input logic inc);
    if (inc && (c != cnt_t'(NEURON_NO))) return c + cnt_t'(1);
    return c;
  endfunction

  scan_state_e     state, state_nxt;
  addr_t           addr;
  logic [DCW-1:0]  dcnt;
  cnt_t            run_cnt, spike_cnt_q;
  logic            overrun_q;
  pot_t            v_th_q;
  logic            rd_en;
  logic            vld_p0;
  ampl_t           a_p0, b_p0;
  addr_t           addr_p0;
  logic            vld_p1, spk_p1;
  pot_t            v_p1;
  addr_t           addr_p1;
  logic            out_vld, out_spk;
  pot_t            out_v;
  addr_t           out_addr;
  logic            sp_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.tick)          state_nxt = SCAN;
      SCAN:    if (addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (dcnt == DRAIN_END) state_nxt = DONE;
      DONE:                           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      dcnt        <= '0;
      run_cnt     <= '0;
      spike_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.tick && (state != IDLE)) overrun_q <= 1'b1;
      run_cnt <= sat_inc(run_cnt, sp_out);
      case (state)
        IDLE: if (bus.tick) begin
          addr    <= '0;
          run_cnt <= '0;
        end
        SCAN: begin
          dcnt <= '0;
          if (addr != LAST_ADDR) addr <= addr + addr_t'(1);
        end
        DRAIN: dcnt <= dcnt + DCW'(1);
        // The final result leaves the pipe in this cycle, so fold it in here.
        DONE:  spike_cnt_q <= sat_inc(run_cnt, sp_out);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.tick) v_th_q <= bus.v_th;
  end

  assign rd_en = (state == SCAN);

  // ---- read -> stage 0 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= rd_en;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      a_p0    <= bus.ampl_a_in;
      b_p0    <= bus.ampl_b_in;
      addr_p0 <= addr;
    end
  end

  membrane_calc u_calc (
    .clk        (clk),
    .reset      (reset),
    .vld_p0     (vld_p0),
    .a_p0       (a_p0),
    .b_p0       (b_p0),
    .addr_p0    (addr_p0),
    .v_th       (v_th_q),
`ifdef REFRACTORY_EN
    .ref_period (bus.ref_period),
`endif
    .vld_p1     (vld_p1),
    .spk_p1     (spk_p1),
    .v_p1       (v_p1),
    .addr_p1    (addr_p1)
  );

  // ---- stage 1 -> output (LAT-2 delay stages; data held between results) ----
  if (LAT == 2) begin : g_nodly
    assign out_vld  = vld_p1;
    assign out_spk  = spk_p1;
    assign out_v    = v_p1;
    assign out_addr = addr_p1;
  end else begin : g_dly
    logic  dly_vld  [LAT-2];
    logic  dly_spk  [LAT-2];
    pot_t  dly_v    [LAT-2];
    addr_t dly_addr [LAT-2];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < LAT-2; k++) begin
          dly_vld[k]  <= 1'b0;
          dly_spk[k]  <= 1'b0;
          dly_v[k]    <= '0;
          dly_addr[k] <= '0;
        end
      end else begin
        dly_vld[0] <= vld_p1;
        dly_spk[0] <= spk_p1;
        if (vld_p1) begin
          dly_v[0]    <= v_p1;
          dly_addr[0] <= addr_p1;
        end
        for (int k = 1; k < LAT-2; k++) begin
          dly_vld[k] <= dly_vld[k-1];
          dly_spk[k] <= dly_spk[k-1];
          if (dly_vld[k-1]) begin
            dly_v[k]    <= dly_v[k-1];
            dly_addr[k] <= dly_addr[k-1];
          end
        end
      end
    end

    assign out_vld  = dly_vld[LAT-3];
    assign out_spk  = dly_spk[LAT-3];
    assign out_v    = dly_v[LAT-3];
    assign out_addr = dly_addr[LAT-3];
  end

  assign sp_out        = out_vld & out_spk;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = addr;
  assign bus.sp_out    = sp_out;
  assign bus.sp_addr   = out_addr;
  assign bus.v_out     = out_v;
  assign bus.v_valid   = out_vld;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.spike_cnt = spike_cnt_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_membrane_scan.sv
// Directed bench for membrane_scan: sweeps with hand-computed spikes, potentials and timing.
`timescale 1ns/1ps
module tb_membrane_scan;
  import snn_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  membrane_scan_if bus();

  membrane_scan #(.LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ampl_t mem_a [NEURON_NO];
  ampl_t mem_b [NEURON_NO];
  assign bus.ampl_a_in = mem_a[bus.rd_addr];
  assign bus.ampl_b_in = mem_b[bus.rd_addr];

  int tick_cyc, first_rd, rd_cnt, addr_err, vv_cnt, sp_cnt, done_cnt, done_cyc;
  int rd_cyc [NEURON_NO];
  int sp_cyc [NEURON_NO];
  int vv_val [NEURON_NO];
  bit sp_flag [NEURON_NO];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NEURON_NO; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  task automatic run_sweep(input int extra_at);
    for (int i = 0; i < NEURON_NO; i++) begin
      rd_cyc[i]  = -1;
      sp_cyc[i]  = -1;
      vv_val[i]  = 0;
      sp_flag[i] = 1'b0;
    end
    rd_cnt = 0; addr_err = 0; vv_cnt = 0; sp_cnt = 0;
    done_cnt = 0; done_cyc = -1; first_rd = -1;
    @(posedge clk); #1;
    bus.tick = 1'b1;
    tick_cyc = cyc;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    for (int n = 0; n < 2*NEURON_NO + 50; n++) begin
      @(negedge clk);
      bus.tick = (extra_at >= 0) && (cyc == tick_cyc + extra_at);
      if (bus.rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (int'(bus.rd_addr) != rd_cnt) addr_err++;
        rd_cyc[bus.rd_addr] = cyc;
        rd_cnt++;
      end
      if (bus.v_valid) begin
        vv_cnt++;
        vv_val[bus.sp_addr] = int'(bus.v_out);
      end
      if (bus.sp_out) begin
        sp_cnt++;
        sp_flag[bus.sp_addr] = 1'b1;
        sp_cyc[bus.sp_addr]  = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    bus.tick = 1'b0;
  endtask

  initial begin
    int hit, nd, nb;
    bus.tick = 1'b0;
    bus.v_th = '0;
`ifdef REFRACTORY_EN
    bus.ref_period = '0;
`endif
    clear_mem();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en",     32'(bus.rd_en), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_done",      32'(bus.done), 0);
    check("rst_sp_out",    32'(bus.sp_out), 0);
    check("rst_v_valid",   32'(bus.v_valid), 0);
    check("rst_overrun",   32'(bus.overrun), 0);
    check("rst_spike_cnt", 32'(bus.spike_cnt), 0);
    check("rst_rd_addr",   32'(bus.rd_addr), 0);
    check("rst_sp_addr",   32'(bus.sp_addr), 0);
    check("rst_v_out",     32'(bus.v_out), 0);
    reset = 1'b0;

    // all-zero amplitudes, threshold 1: full sweep, no spikes
    bus.v_th = pot_t'(1);
    run_sweep(-1);
    check("t1_rd_cnt",     rd_cnt, 256);
    check("t1_addr_seq",   addr_err, 0);
    check("t1_first_rd",   first_rd - tick_cyc, 1);
    check("t1_sp_cnt",     sp_cnt, 0);
    check("t1_vv_cnt",     vv_cnt, 256);
    check("t1_done_cnt",   done_cnt, 1);
    check("t1_done_lat",   done_cyc - tick_cyc, 256 + LAT);
    check("t1_spike_cnt",  32'(bus.spike_cnt), 0);
    check("t1_overrun",    32'(bus.overrun), 0);
    check("t1_busy_end",   32'(bus.busy), 0);

    // neuron 5: 100 - 40 = 60 meets threshold 60 exactly
    mem_a[5] = 20'd100;
    mem_b[5] = 20'd40;
    bus.v_th = pot_t'(60);
    run_sweep(-1);
    check("t2_sp_cnt",     sp_cnt, 1);
    check("t2_sp_flag5",   32'(sp_flag[5]), 1);
    check("t2_latency",    sp_cyc[5] - rd_cyc[5], LAT);
    check("t2_v_out5",     vv_val[5], 60);
    check("t2_spike_cnt",  32'(bus.spike_cnt), 1);

    // neuron 9: 0 - 0xFFFFF = -1048575, signed compare; every other neuron has v = 0
    clear_mem();
    mem_b[9] = 20'hFFFFF;
    bus.v_th = pot_t'(-1048575);
    run_sweep(-1);
    check("t3_sp_flag9",   32'(sp_flag[9]), 1);
    check("t3_v_out9",     vv_val[9], -1048575);
    check("t3_sp_cnt",     sp_cnt, 256);
    check("t3_spike_cnt",  32'(bus.spike_cnt), 256);

    // one above the most negative potential: neuron 9 just misses
    bus.v_th = pot_t'(-1048574);
    run_sweep(-1);
    check("t3b_sp_flag9",  32'(sp_flag[9]), 0);
    check("t3b_spike_cnt", 32'(bus.spike_cnt), 255);

    // tick during a sweep: overrun, no restart, one done
    clear_mem();
    mem_a[5] = 20'd100;
    mem_b[5] = 20'd40;
    bus.v_th = pot_t'(60);
    check("t4_overrun_pre", 32'(bus.overrun), 0);
    run_sweep(100);
    check("t4_overrun",    32'(bus.overrun), 1);
    check("t4_done_cnt",   done_cnt, 1);
    check("t4_rd_cnt",     rd_cnt, 256);
    check("t4_spike_cnt",  32'(bus.spike_cnt), 1);
    check("t4_busy_end",   32'(bus.busy), 0);

    // reset at address 128
    @(posedge clk); #1;
    bus.tick = 1'b1;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    hit = 0;
    for (int n = 0; n < 400 && hit == 0; n++) begin
      @(negedge clk);
      if (bus.rd_en && bus.rd_addr == addr_t'(128)) hit = 1;
    end
    check("t5_reach128",   hit, 1);
    reset = 1'b1;
    #1;
    check("t5_rd_en",      32'(bus.rd_en), 0);
    check("t5_busy",       32'(bus.busy), 0);
    check("t5_rd_addr",    32'(bus.rd_addr), 0);
    check("t5_overrun",    32'(bus.overrun), 0);
    check("t5_spike_cnt",  32'(bus.spike_cnt), 0);
    check("t5_sp_addr",    32'(bus.sp_addr), 0);
    check("t5_v_valid",    32'(bus.v_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    nd = 0;
    nb = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.busy) nb++;
    end
    check("t5_no_done",    nd, 0);
    check("t5_idle",       nb, 0);
    run_sweep(-1);
    check("t5_restart_rd", first_rd - tick_cyc, 1);
    check("t5_addr_seq",   addr_err, 0);
    check("t5_rd_cnt",     rd_cnt, 256);
    check("t5_spike_cnt",  32'(bus.spike_cnt), 1);

`ifdef REFRACTORY_EN
    // refractory period 2: neuron 3 fires on ticks 1 and 4 only
    clear_mem();
    mem_a[3] = 20'd100;
    mem_b[3] = 20'd40;
    bus.v_th = pot_t'(60);
    bus.ref_period = ref_t'(2);
    for (int t = 0; t < 4; t++) begin
      run_sweep(-1);
      check($sformatf("t6_sp3_tick%0d", t + 1), 32'(sp_flag[3]), (t == 0 || t == 3) ? 1 : 0);
      check($sformatf("t6_v3_tick%0d", t + 1), vv_val[3], 60);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
